// File: rtl/sw_column_feeder_if.sv
// sw_column_feeder_if: memory read port and column side-input stream.
// master = feeder (drives reads, column beats), slave = memory/shift chain.
interface sw_column_feeder_if #(
  parameter int AW = 16
);
  logic          mem_rd_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_data_i;
  logic [31:0]   col_word_o;
  logic          col_valid_o;
  logic          col_ready_i;
  logic          row_first_o;
  logic          row_last_o;
  logic          win_last_o;

  modport master (
    output mem_rd_o,
    output mem_addr_o,
    input  mem_data_i,
    output col_word_o,
    output col_valid_o,
    input  col_ready_i,
    output row_first_o,
    output row_last_o,
    output win_last_o
  );

  modport slave (
    input  mem_rd_o,
    input  mem_addr_o,
    output mem_data_i,
    input  col_word_o,
    input  col_valid_o,
    output col_ready_i,
    input  row_first_o,
    input  row_last_o,
    input  win_last_o
  );
endinterface

// File: rtl/sw_column_feeder.sv
// sw_column_feeder: walks a ROWS x COLS window of 32-bit words and streams
// them to the search-window shift chain with row/window markers.
// Ports: clk_i, rst_i (sync, active-high), start_i, abort_i,
//   base_addr_i, stride_i (latched on start), busy_o, done_o,
//   bus (master): mem read port + column valid/ready stream.
module sw_column_feeder #(
  parameter int ROWS = 16,
  parameter int COLS = 8,
  parameter int AW   = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic [AW-1:0] stride_i,
  output logic          busy_o,
  output logic          done_o,
  sw_column_feeder_if.master bus
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [AW-1:0] row_base_q;
  logic [AW-1:0] stride_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic          busy_q;
  logic          done_q;

  // Read in flight and the tags it will carry into the buffer.
  logic          rd_q;
  logic [2:0]    tag_q;

  // Two-entry buffer: head drives the outputs, tail backs it up.
  // Tag bits: [2] row first, [1] row last, [0] window last.
  logic [1:0]    cnt_q;
  logic [31:0]   hd_w_q;
  logic [2:0]    hd_t_q;
  logic [31:0]   tl_w_q;
  logic [2:0]    tl_t_q;

  logic          valid;
  logic          pop;
  logic          rd;
  logic          last_col;
  logic          last_row;
  logic [2:0]    occ;
  logic [2:0]    need;
  logic [2:0]    tag_new;

  assign valid    = (cnt_q != 2'd0);
  assign pop      = valid && bus.col_ready_i;
  assign last_col = (col_q == CW'(COLS - 1));
  assign last_row = (row_q == RW'(ROWS - 1));
  assign occ      = {1'b0, cnt_q} + {2'b00, rd_q};
  // Space left after this cycle's pop must cover a new read.
  assign need     = occ - {2'b00, pop};
  assign rd       = (state_q == S_RUN) && (need < 3'd2);
  assign tag_new  = {(col_q == '0), last_col, last_col && last_row};

  assign bus.mem_rd_o    = rd;
  assign bus.mem_addr_o  = rd ? (row_base_q + AW'(col_q)) : '0;
  assign bus.col_valid_o = valid;
  assign bus.col_word_o  = hd_w_q;
  assign bus.row_first_o = valid && hd_t_q[2];
  assign bus.row_last_o  = valid && hd_t_q[1];
  assign bus.win_last_o  = valid && hd_t_q[0];
  assign busy_o          = busy_q;
  assign done_o          = done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      row_base_q <= '0;
      stride_q   <= '0;
      row_q      <= '0;
      col_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_q       <= 1'b0;
      tag_q      <= '0;
      cnt_q      <= '0;
      hd_w_q     <= '0;
      hd_t_q     <= '0;
      tl_w_q     <= '0;
      tl_t_q     <= '0;
    end else begin
      done_q <= 1'b0;
      rd_q   <= rd;
      tag_q  <= tag_new;

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q    <= S_RUN;
            row_base_q <= base_addr_i;
            stride_q   <= stride_i;
            row_q      <= '0;
            col_q      <= '0;
            busy_q     <= 1'b1;
          end
        end
        S_RUN: begin
          if (rd) begin
            if (last_col) begin
              col_q      <= '0;
              row_q      <= row_q + RW'(1);
              row_base_q <= row_base_q + stride_q;
              if (last_row) begin
                state_q <= S_DRAIN;
              end
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (pop && hd_t_q[0]) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      // Credit rule guarantees no push while the buffer is full.
      case ({rd_q, pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            hd_w_q <= bus.mem_data_i;
            hd_t_q <= tag_q;
          end else begin
            tl_w_q <= bus.mem_data_i;
            tl_t_q <= tag_q;
          end
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          hd_w_q <= tl_w_q;
          hd_t_q <= tl_t_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            hd_w_q <= bus.mem_data_i;
            hd_t_q <= tag_q;
          end else begin
            hd_w_q <= tl_w_q;
            hd_t_q <= tl_t_q;
            tl_w_q <= bus.mem_data_i;
            tl_t_q <= tag_q;
          end
        end
        default: ;
      endcase

      // Abort drops buffered words and the pending return.
      if (abort_i && (state_q != S_IDLE)) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
        rd_q    <= 1'b0;
        cnt_q   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sw_column_feeder.sv
// tb_sw_column_feeder: scenario tasks against a window-walk reference
// model (address arithmetic, ordered word/tag lists, occupancy bound).
module tb_sw_column_feeder;

  localparam int ROWS = 2;
  localparam int COLS = 4;
  localparam int AW   = 16;
  localparam int N    = ROWS * COLS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] base = '0;
  logic [15:0] stride = '0;
  logic        rdy = 1'b1;
  logic        busy;
  logic        done;
  logic [31:0] key = 32'h0;
  logic [31:0] mem_q = 32'h0;

  int nt = 0;
  int nf = 0;

  sw_column_feeder_if #(.AW(AW)) bus ();

  sw_column_feeder #(
    .ROWS(ROWS),
    .COLS(COLS),
    .AW  (AW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .abort_i    (abort),
    .base_addr_i(base),
    .stride_i   (stride),
    .busy_o     (busy),
    .done_o     (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ key[31:16], ~a ^ key[15:0]};
  endfunction

  always @(posedge clk) begin
    if (bus.mem_rd_o === 1'b1) mem_q <= mem_word(bus.mem_addr_o);
  end
  assign bus.mem_data_i  = mem_q;
  assign bus.col_ready_i = rdy;

  typedef struct {
    logic        rd;
    logic [15:0] a;
    logic        v;
    logic        r;
    logic [31:0] w;
    logic [2:0]  t;
    logic        busy;
    logic        done;
  } smp_t;

  smp_t smp[$];

  always @(negedge clk) begin : mon
    smp_t s;
    s.rd   = bus.mem_rd_o;
    s.a    = bus.mem_addr_o;
    s.v    = bus.col_valid_o;
    s.r    = bus.col_ready_i;
    s.w    = bus.col_word_o;
    s.t    = {bus.row_first_o, bus.row_last_o, bus.win_last_o};
    s.busy = busy;
    s.done = done;
    smp.push_back(s);
  end

  // Reference model: window order is row-major, address wraps mod 2^16.
  function automatic logic [15:0] exp_addr(input logic [15:0] b,
                                           input logic [15:0] s,
                                           input int i);
    int v;
    v = int'(b) + (i / COLS) * int'(s) + (i % COLS);
    return v[15:0];
  endfunction

  function automatic logic [2:0] exp_tag(input int i);
    return {(i % COLS) == 0, (i % COLS) == COLS - 1, i == N - 1};
  endfunction

  logic [15:0] ra[$];
  int          rc[$];
  logic [31:0] bw[$];
  logic [2:0]  bt[$];
  int          bc[$];
  int          dc[$];
  int          occ_max;
  int          unstable;

  task automatic drive(input logic [15:0] b, input logic [15:0] s,
                       input int n, input logic [63:0] st_x,
                       input logic [63:0] rlo, input logic [63:0] ab,
                       input logic [63:0] rs, input int pct,
                       output int s0);
    base = b;
    stride = s;
    s0 = smp.size();
    for (int j = 0; j < n; j++) begin
      start = (j == 0) || st_x[j];
      abort = ab[j];
      rst   = rs[j];
      rdy   = !rlo[j] &&
              (pct == 0 || j >= 40 || int'($urandom % 100) < pct);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    rdy   = 1'b1;
  endtask

  task automatic collect(input int s0, input int n);
    int oc;
    ra.delete(); rc.delete(); bw.delete();
    bt.delete(); bc.delete(); dc.delete();
    oc = 0;
    occ_max = 0;
    unstable = 0;
    for (int j = 0; j < n; j++) begin
      smp_t s;
      s = smp[s0 + j];
      if (s.rd) begin ra.push_back(s.a); rc.push_back(j); end
      if (s.v && s.r) begin
        bw.push_back(s.w); bt.push_back(s.t); bc.push_back(j);
      end
      if (s.done) dc.push_back(j);
      if (j > 0) begin
        smp_t p;
        p = smp[s0 + j - 1];
        if (p.v && !p.r && (!s.v || s.w !== p.w || s.t !== p.t))
          unstable++;
      end
      oc = oc + int'(s.rd) - int'(s.v && s.r);
      if (oc > occ_max) occ_max = oc;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nt++;
    if ({bus.mem_rd_o, bus.mem_addr_o} !== 17'h0) begin
      nf++;
      $display("FAIL reset_mem: got %0h want 0",
               {bus.mem_rd_o, bus.mem_addr_o});
    end
    nt++;
    if ({bus.col_valid_o, bus.col_word_o, bus.row_first_o,
         bus.row_last_o, bus.win_last_o} !== 36'h0) begin
      nf++;
      $display("FAIL reset_col: valid %b word %0h want 0",
               bus.col_valid_o, bus.col_word_o);
    end
    nt++;
    if ({busy, done} !== 2'b00) begin
      nf++;
      $display("FAIL reset_status: got %b want 00", {busy, done});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    int s0;
    logic [15:0] b;
    logic [15:0] s;
    b = 16'h0100;
    s = 16'h0040;
    drive(b, s, 14, 0, 0, 0, 0, 0, s0);
    collect(s0, 14);
    nt++;
    if (ra.size() != N || bw.size() != N) begin
      nf++;
      $display("FAIL basic_counts: reads %0d beats %0d want %0d",
               ra.size(), bw.size(), N);
    end
    for (int i = 0; i < N && i < ra.size() && i < bw.size(); i++) begin
      nt++;
      if (ra[i] !== exp_addr(b, s, i) || rc[i] != i + 1 ||
          bw[i] !== mem_word(exp_addr(b, s, i)) || bt[i] !== exp_tag(i) ||
          bc[i] != i + 3) begin
        nf++;
        $display("FAIL basic_beat%0d: addr %0h@%0d word %0h tag %b @%0d want %0h@%0d %0h %b @%0d",
                 i, ra[i], rc[i], bw[i], bt[i], bc[i], exp_addr(b, s, i),
                 i + 1, mem_word(exp_addr(b, s, i)), exp_tag(i), i + 3);
      end
    end
    nt++;
    if (dc.size() != 1 || dc[0] != N + 3) begin
      nf++;
      $display("FAIL basic_done: count %0d first %0d want 1 at %0d",
               dc.size(), (dc.size() > 0) ? dc[0] : -1, N + 3);
    end
    nt++;
    if ({smp[s0+1].busy, smp[s0+N+2].busy, smp[s0+N+3].busy,
         smp[s0+N+4].busy} !== 4'b1100) begin
      nf++;
      $display("FAIL basic_busy: got %b want 1100",
               {smp[s0+1].busy, smp[s0+N+2].busy, smp[s0+N+3].busy,
                smp[s0+N+4].busy});
    end
  endtask

  task automatic test_stall;
    int s0;
    int early;
    logic [15:0] b;
    logic [15:0] s;
    b = 16'h0100;
    s = 16'h0040;
    drive(b, s, 24, 0, 64'h3F0, 0, 0, 0, s0);
    collect(s0, 24);
    early = 0;
    foreach (rc[i]) if (rc[i] >= 4 && rc[i] <= 9) early++;
    nt++;
    if (early > 2 || occ_max > 2) begin
      nf++;
      $display("FAIL stall_credit: stalled reads %0d occ %0d want <=2 <=2",
               early, occ_max);
    end
    nt++;
    if (unstable != 0) begin
      nf++;
      $display("FAIL stall_hold: changes %0d want 0", unstable);
    end
    nt++;
    if (bw.size() != N) begin
      nf++;
      $display("FAIL stall_count: beats %0d want %0d", bw.size(), N);
    end
    for (int i = 0; i < N && i < bw.size(); i++) begin
      nt++;
      if (bw[i] !== mem_word(exp_addr(b, s, i)) || bt[i] !== exp_tag(i)) begin
        nf++;
        $display("FAIL stall_beat%0d: word %0h tag %b want %0h %b", i,
                 bw[i], bt[i], mem_word(exp_addr(b, s, i)), exp_tag(i));
      end
    end
    nt++;
    if (dc.size() != 1 || bc.size() == 0 || dc[0] != bc[bc.size()-1] + 1) begin
      nf++;
      $display("FAIL stall_done: count %0d want 1 after last beat",
               dc.size());
    end
  endtask

  task automatic test_wrap;
    int s0;
    logic [15:0] want[8];
    want = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001,
             16'h000E, 16'h000F, 16'h0010, 16'h0011};
    drive(16'hFFFE, 16'h0010, 14, 0, 0, 0, 0, 0, s0);
    collect(s0, 14);
    nt++;
    if (ra.size() != N) begin
      nf++;
      $display("FAIL wrap_count: reads %0d want %0d", ra.size(), N);
    end
    for (int i = 0; i < N && i < ra.size(); i++) begin
      nt++;
      if (ra[i] !== want[i] || ra[i] !== exp_addr(16'hFFFE, 16'h0010, i)) begin
        nf++;
        $display("FAIL wrap_addr%0d: got %0h want %0h", i, ra[i], want[i]);
      end
    end
  endtask

  task automatic test_abort;
    int s0;
    int s1;
    logic [15:0] b1;
    logic [15:0] s1v;
    logic [15:0] b2;
    logic [15:0] s2v;
    b1 = 16'($urandom);
    s1v = 16'($urandom);
    b2 = 16'($urandom);
    s2v = 16'($urandom);
    drive(b1, s1v, 7, 0, 0, 64'h20, 0, 0, s0);
    drive(b2, s2v, 16, 0, 0, 0, 0, 0, s1);
    nt++;
    if ({smp[s0+6].v, smp[s0+6].rd, smp[s0+6].busy, smp[s0+6].done} !== 4'b0) begin
      nf++;
      $display("FAIL abort_quiet: v/rd/busy/done %b want 0000",
               {smp[s0+6].v, smp[s0+6].rd, smp[s0+6].busy, smp[s0+6].done});
    end
    collect(s0, 7);
    nt++;
    if (dc.size() != 0) begin
      nf++;
      $display("FAIL abort_nodone: done pulses %0d want 0", dc.size());
    end
    collect(s1, 16);
    nt++;
    if (ra.size() != N || bw.size() != N || dc.size() != 1 ||
        dc[0] != N + 3) begin
      nf++;
      $display("FAIL abort_restart: reads %0d beats %0d done %0d want %0d %0d 1",
               ra.size(), bw.size(), dc.size(), N, N);
    end
    for (int i = 0; i < N && i < ra.size() && i < bw.size(); i++) begin
      nt++;
      if (ra[i] !== exp_addr(b2, s2v, i) || rc[i] != i + 1 ||
          bw[i] !== mem_word(exp_addr(b2, s2v, i)) || bc[i] != i + 3) begin
        nf++;
        $display("FAIL abort_beat%0d: addr %0h word %0h want %0h %0h", i,
                 ra[i], bw[i], exp_addr(b2, s2v, i),
                 mem_word(exp_addr(b2, s2v, i)));
      end
    end
  endtask

  task automatic test_start_ignored;
    int s0;
    logic [15:0] b;
    logic [15:0] s;
    b = 16'($urandom);
    s = 16'($urandom);
    drive(b, s, 16, 64'h808, 0, 0, 0, 0, s0);
    collect(s0, 16);
    nt++;
    if (ra.size() != N || dc.size() != 1 || dc[0] != N + 3) begin
      nf++;
      $display("FAIL ign_counts: reads %0d done %0d want %0d 1",
               ra.size(), dc.size(), N);
    end
    for (int i = 0; i < N && i < ra.size(); i++) begin
      nt++;
      if (ra[i] !== exp_addr(b, s, i) || rc[i] != i + 1) begin
        nf++;
        $display("FAIL ign_addr%0d: got %0h@%0d want %0h@%0d", i, ra[i],
                 rc[i], exp_addr(b, s, i), i + 1);
      end
    end
    nt++;
    if ({smp[s0+12].busy, smp[s0+13].busy, smp[s0+15].busy} !== 3'b000) begin
      nf++;
      $display("FAIL ign_idle: busy %b want 000",
               {smp[s0+12].busy, smp[s0+13].busy, smp[s0+15].busy});
    end
  endtask

  task automatic test_reset_mid;
    int s0;
    int s1;
    logic [15:0] b;
    logic [15:0] s;
    smp_t z;
    drive(16'($urandom), 16'($urandom), 8, 0, 0, 0, 64'h20, 0, s0);
    z = smp[s0+6];
    nt++;
    if ({z.rd, z.a, z.v, z.w, z.t, z.busy, z.done} !== 55'h0) begin
      nf++;
      $display("FAIL rstmid_zero: rd %b addr %0h v %b word %0h tag %b busy %b done %b want 0",
               z.rd, z.a, z.v, z.w, z.t, z.busy, z.done);
    end
    b = 16'($urandom);
    s = 16'($urandom);
    drive(b, s, 14, 0, 0, 0, 0, 0, s1);
    collect(s1, 14);
    nt++;
    if (ra.size() != N || bw.size() != N || dc.size() != 1 ||
        dc[0] != N + 3) begin
      nf++;
      $display("FAIL rstmid_counts: reads %0d beats %0d done %0d want %0d %0d 1",
               ra.size(), bw.size(), dc.size(), N, N);
    end
    for (int i = 0; i < N && i < ra.size() && i < bw.size(); i++) begin
      nt++;
      if (ra[i] !== exp_addr(b, s, i) || rc[i] != i + 1 ||
          bw[i] !== mem_word(exp_addr(b, s, i)) || bc[i] != i + 3) begin
        nf++;
        $display("FAIL rstmid_beat%0d: addr %0h word %0h want %0h %0h", i,
                 ra[i], bw[i], exp_addr(b, s, i), mem_word(exp_addr(b, s, i)));
      end
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 6; it++) begin
      int s0;
      int pct;
      logic [15:0] b;
      logic [15:0] s;
      b = 16'($urandom);
      s = 16'($urandom);
      pct = 40 + int'($urandom % 50);
      drive(b, s, 64, 0, 0, 0, 0, pct, s0);
      collect(s0, 64);
      nt++;
      if (ra.size() != N || bw.size() != N || occ_max > 2 || unstable != 0) begin
        nf++;
        $display("FAIL rand%0d_flow: reads %0d beats %0d occ %0d changes %0d want %0d %0d <=2 0",
                 it, ra.size(), bw.size(), occ_max, unstable, N, N);
      end
      for (int i = 0; i < N && i < ra.size() && i < bw.size(); i++) begin
        nt++;
        if (ra[i] !== exp_addr(b, s, i) ||
            bw[i] !== mem_word(exp_addr(b, s, i)) || bt[i] !== exp_tag(i)) begin
          nf++;
          $display("FAIL rand%0d_beat%0d: addr %0h word %0h tag %b want %0h %0h %b",
                   it, i, ra[i], bw[i], bt[i], exp_addr(b, s, i),
                   mem_word(exp_addr(b, s, i)), exp_tag(i));
        end
      end
      nt++;
      if (dc.size() != 1 || bc.size() == 0 || dc[0] != bc[bc.size()-1] + 1) begin
        nf++;
        $display("FAIL rand%0d_done: pulses %0d want 1 after last beat",
                 it, dc.size());
      end
    end
  endtask

  initial begin
    key = $urandom;
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

endmodule
